// File: rtl/fir_pkg.sv
// Shared constants and types for the 10-tap FIR datapath and its tap feeder.
package fir_pkg;

  localparam int unsigned TAPS     = 10;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned FIR_LAT  = 10;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } feeder_state_e;

  typedef logic [TAPS-1:0][SAMPLE_W-1:0] tap_array_t;

endpackage

// File: rtl/valid_delay.sv
// Parameterised-depth 1-bit shift register; marks which FIR outputs are meaningful.
module valid_delay #(
  parameter int unsigned DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= d;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_tap_feeder.sv
// Tap window feeder for the 10-tap FIR: shifts accepted samples into x0..x9,
// drains with zeros on flush, and strobes y_valid in step with the FIR output.
module fir_tap_feeder
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] x0,
  output logic [SAMPLE_W-1:0] x1,
  output logic [SAMPLE_W-1:0] x2,
  output logic [SAMPLE_W-1:0] x3,
  output logic [SAMPLE_W-1:0] x4,
  output logic [SAMPLE_W-1:0] x5,
  output logic [SAMPLE_W-1:0] x6,
  output logic [SAMPLE_W-1:0] x7,
  output logic [SAMPLE_W-1:0] x8,
  output logic [SAMPLE_W-1:0] x9,
  output logic                taps_valid,
  output logic                y_valid,
  output logic [CNT_W-1:0]    fill_count,
  output logic                busy
);

  localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  feeder_state_e         state;
  feeder_state_e         state_nx;
  tap_array_t            taps;
  logic [CNT_W-1:0]      fill_nx;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      flush_cnt_nx;
  logic                  accept;
  logic                  advance;
  logic                  taps_valid_nx;
  logic                  upd_q;
  logic [SAMPLE_W-1:0]   shift_in;

  // in_ready is already low throughout FLUSH; the state term keeps accept explicit
  assign accept   = in_valid & in_ready & (state != FLUSH);
  assign advance  = accept | (state == FLUSH);
  assign shift_in = (state == FLUSH) ? '0 : in_data;

  // Next-state, fill and flush counters
  always_comb begin
    state_nx     = state;
    fill_nx      = fill_count;
    flush_cnt_nx = flush_cnt;
    unique case (state)
      IDLE, FILL, RUN: begin
        if (accept) begin
          fill_nx  = (fill_count >= TAPS_CNT) ? TAPS_CNT : fill_count + ONE_CNT;
          state_nx = (fill_nx == TAPS_CNT) ? RUN : FILL;
        end
        // A flush coinciding with an accept still lets that sample in first
        if (flush && (state != IDLE)) begin
          state_nx     = FLUSH;
          flush_cnt_nx = TAPS_CNT;
        end
      end
      FLUSH: begin
        // Flush zeros count as window samples, so a partial window can become valid
        fill_nx      = (fill_count >= TAPS_CNT) ? TAPS_CNT : fill_count + ONE_CNT;
        flush_cnt_nx = flush_cnt - ONE_CNT;
        if (flush_cnt == ONE_CNT) begin
          state_nx     = IDLE;
          fill_nx      = '0;
          flush_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign taps_valid_nx = (fill_nx == TAPS_CNT) && (state_nx != IDLE);

  // State, registered outputs and tap shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      fill_count <= '0;
      flush_cnt  <= '0;
      taps_valid <= 1'b0;
      upd_q      <= 1'b0;
      taps       <= '0;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx != FLUSH);
      busy       <= (state_nx == FLUSH);
      fill_count <= fill_nx;
      flush_cnt  <= flush_cnt_nx;
      taps_valid <= taps_valid_nx;
      upd_q      <= advance & taps_valid_nx;
      if (advance) begin
        taps <= {taps[TAPS-2:0], shift_in};
      end
    end
  end

  assign x0 = taps[0];
  assign x1 = taps[1];
  assign x2 = taps[2];
  assign x3 = taps[3];
  assign x4 = taps[4];
  assign x5 = taps[5];
  assign x6 = taps[6];
  assign x7 = taps[7];
  assign x8 = taps[8];
  assign x9 = taps[9];

  // upd_q marks the edge the window changed; the FIR registers Y FIR_LAT edges later
  valid_delay #(
    .DEPTH (FIR_LAT)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d   (upd_q),
    .q   (y_valid)
  );

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed self-checking bench for fir_tap_feeder.
module tb_fir_tap_feeder;
  import fir_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_ready;
  logic                flush;
  logic [SAMPLE_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
  logic                taps_valid;
  logic                y_valid;
  logic [CNT_W-1:0]    fill_count;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int y_edges[$];
  int acc_edge[13];
  int e10;
  int ef;
  int es;

  always #5 clk = ~clk;

  fir_tap_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4),
    .x5         (x5),
    .x6         (x6),
    .x7         (x7),
    .x8         (x8),
    .x9         (x9),
    .taps_valid (taps_valid),
    .y_valid    (y_valid),
    .fill_count (fill_count),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge; outputs are read 1 time unit later and y_valid highs are logged
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (y_valid) y_edges.push_back(cyc);
  endtask

  function automatic int edge_at(input int idx);
    return (idx < y_edges.size()) ? y_edges[idx] : -1;
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    flush    = 1'b0;

    // Reset held two cycles with in_valid high
    step();
    step();
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_x0",         32'(x0),         32'd0);
    check("rst_x9",         32'(x9),         32'd0);
    check("rst_taps_valid", 32'(taps_valid), 32'd0);
    check("rst_y_valid",    32'(y_valid),    32'd0);
    check("rst_fill_count", 32'(fill_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Flush in IDLE is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("idle_flush_ready", 32'(in_ready), 32'd1);
    check("idle_flush_busy",  32'(busy),     32'd0);

    // Fill 1..10 back-to-back
    y_edges.delete();
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      check("fill_count_step", 32'(fill_count), 32'(i));
      check("fill_taps_valid", 32'(taps_valid), (i == 10) ? 32'd1 : 32'd0);
    end
    e10      = cyc;
    in_valid = 1'b0;
    check("fill_x0", 32'(x0), 32'd10);
    check("fill_x5", 32'(x5), 32'd5);
    check("fill_x9", 32'(x9), 32'd1);
    for (int k = 0; k < 12; k++) step();
    check("fill_y_count", 32'(y_edges.size()), 32'd1);
    check("fill_y_edge",  32'(edge_at(0)),     32'(e10 + 10));

    // Flush from RUN; data offered during FLUSH must not be captured
    y_edges.delete();
    flush = 1'b1;
    step();
    ef       = cyc;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int k = 0; k < 10; k++) begin
      check("flush_ready_busy", {30'd0, in_ready, busy}, 32'd1);
      if (k == 1) begin
        check("flush_x0_zero", 32'(x0), 32'd0);
        check("flush_x1",      32'(x1), 32'd10);
        check("flush_x9",      32'(x9), 32'd2);
      end
      step();
    end
    in_valid = 1'b0;
    check("flush_end_ready", 32'(in_ready),   32'd1);
    check("flush_end_busy",  32'(busy),       32'd0);
    check("flush_end_fill",  32'(fill_count), 32'd0);
    check("flush_end_tv",    32'(taps_valid), 32'd0);
    check("flush_end_x0",    32'(x0),         32'd0);
    check("flush_end_x9",    32'(x9),         32'd0);
    for (int k = 0; k < 12; k++) step();
    check("flush_y_count", 32'(y_edges.size()), 32'd9);
    check("flush_y_first", 32'(edge_at(0)),     32'(ef + 11));
    check("flush_y_last",  32'(edge_at(8)),     32'(ef + 19));

    // Samples 1..12 with a gap cycle after each
    y_edges.delete();
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      acc_edge[i] = cyc;
      check("gap_fill", 32'(fill_count), (i >= 10) ? 32'd10 : 32'(i));
      in_valid = 1'b0;
      in_data  = 8'hEE;
      step();
      check("gap_hold_x0", 32'(x0), 32'(i));
    end
    check("gap_x0", 32'(x0), 32'd12);
    check("gap_x9", 32'(x9), 32'd3);
    for (int k = 0; k < 14; k++) step();
    check("gap_y_count", 32'(y_edges.size()), 32'd3);
    check("gap_y_10", 32'(edge_at(0)), 32'(acc_edge[10] + 10));
    check("gap_y_11", 32'(edge_at(1)), 32'(acc_edge[11] + 10));
    check("gap_y_12", 32'(edge_at(2)), 32'(acc_edge[12] + 10));

    // Flush coinciding with an accepted sample in RUN
    in_valid = 1'b1;
    in_data  = 8'h55;
    flush    = 1'b1;
    step();
    es       = cyc;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("sim_x0",    32'(x0),       32'h55);
    check("sim_x1",    32'(x1),       32'd12);
    check("sim_ready", 32'(in_ready), 32'd0);
    check("sim_busy",  32'(busy),     32'd1);
    step();
    check("sim_zero_x0", 32'(x0), 32'd0);
    check("sim_zero_x1", 32'(x1), 32'h55);
    for (int k = 0; k < 9; k++) step();
    check("sim_end_ready", 32'(in_ready),   32'd1);
    check("sim_end_fill",  32'(fill_count), 32'd0);
    check("sim_end_x9",    32'(x9),         32'd0);
    check("sim_end_edges", 32'(cyc - es),   32'd10);

    // Reset during the fourth FLUSH cycle drops every pending y_valid
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 100);
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    step();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_ready", 32'(in_ready),   32'd1);
    check("mid_busy",  32'(busy),       32'd0);
    check("mid_fill",  32'(fill_count), 32'd0);
    check("mid_tv",    32'(taps_valid), 32'd0);
    check("mid_x0",    32'(x0),         32'd0);
    check("mid_x3",    32'(x3),         32'd0);
    y_edges.delete();
    for (int k = 0; k < 20; k++) step();
    check("mid_y_none", 32'(y_edges.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
